// File: rtl/load_pkg.sv
// Shared definitions for the load unit: RV32I load func3 codes, sequencer states,
// legal memory-latency range and access-legality helpers.
package load_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int unsigned MEM_LATENCY_MIN = 1;
   localparam int unsigned MEM_LATENCY_MAX = 8;
   localparam int unsigned CNT_W           = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   function automatic logic f3_legal(input logic [2:0] f3);
      return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'b00);
   endfunction

   // Forces halfword/word offsets down to their natural alignment.
   function automatic logic [1:0] natural_off(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_LH, F3_LHU: return {off[1], 1'b0};
         F3_LW:         return 2'b00;
         default:       return off;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the addressed byte/halfword/word out of a
// memory word and sign- or zero-extends it to 32 bits.
module load_align
   import load_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'(word >> {off, 3'b000});
      half_sel = 16'(word >> {off[1], 4'b0000});
      result   = '0;
      case (func3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {24'h0, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  result = {16'h0, half_sel};
         F3_LW:   result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// RV32I load sequencer: word-aligned read, fixed memory latency, extract and extend.
// Build option LOAD_MISALIGN_TRAP_EN: misaligned loads raise ld_err instead of being aligned.
module load_unit
   import load_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   input  logic [2:0]        ld_func3,
   input  logic [ADDR_W-1:0] ld_addr,
   output logic              ld_stall,
   output logic              ld_wb_valid,
   output logic [31:0]       ld_wb_data,
   output logic              ld_err,
   output logic              dm_re,
   output logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_rdata
);

   if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
      $error("load_unit: MEM_LATENCY out of range");
   end

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             abort_q;
   logic             wb_valid_q;
   logic [2:0]       func3_q;
   logic [1:0]       off_q;
   logic [31:0]      data_q;
   logic [31:0]      aligned;
   logic             trap;
   logic             start;
   logic             keep;
   logic [1:0]       off_in;

   always_comb begin
`ifdef LOAD_MISALIGN_TRAP_EN
      trap   = !f3_legal(ld_func3) || f3_misaligned(ld_func3, ld_addr[1:0]);
      off_in = ld_addr[1:0];
`else
      trap   = !f3_legal(ld_func3);
      off_in = natural_off(ld_func3, ld_addr[1:0]);
`endif
      // Combinational outputs are gated by rst_n so everything reads 0 while in reset.
      start  = rst_n && (state_q == IDLE) && ld_valid && !trap;
      keep   = ld_valid && !abort_q;
   end

   assign ld_err      = rst_n && (state_q == IDLE) && ld_valid && trap;
   assign dm_re       = start;
   assign dm_addr     = start ? {ld_addr[ADDR_W-1:2], 2'b00} : '0;
   assign ld_stall    = start || (rst_n && (state_q == WAIT) && keep);
   assign ld_wb_valid = wb_valid_q;
   assign ld_wb_data  = data_q;

   load_align u_align (
      .func3  (func3_q),
      .off    (off_q),
      .word   (dm_rdata),
      .result (aligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         abort_q    <= 1'b0;
         wb_valid_q <= 1'b0;
         func3_q    <= '0;
         off_q      <= '0;
         data_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  func3_q <= ld_func3;
                  off_q   <= off_in;
                  cnt_q   <= CNT_W'(MEM_LATENCY);
                  abort_q <= 1'b0;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (!ld_valid) abort_q <= 1'b1;
               // Read data is valid in the cycle the countdown reaches 1.
               if (cnt_q == CNT_W'(1)) begin
                  wb_valid_q <= keep;
                  data_q     <= keep ? aligned : '0;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               wb_valid_q <= 1'b0;
               data_q     <= '0;
               abort_q    <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: two instances (latency 1 and 4) behind a select,
// a latency-accurate memory model and an arithmetic reference for load extraction.
module tb_load_unit;

`ifdef LOAD_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        ld_valid;
   logic [2:0]  ld_func3;
   logic [31:0] ld_addr;

   logic        st1, wbv1, err1, re1, st4, wbv4, err4, re4;
   logic [31:0] wbd1, addr1, rd1, wbd4, addr4, rd4;
   logic        o_stall, o_wbv, o_err, o_re;
   logic [31:0] o_data, o_addr;

   int checks;
   int failures;

   logic [31:0] mem [256];
   logic [31:0] p1;
   logic [31:0] p4 [4];

   load_unit #(.MEM_LATENCY(1), .ADDR_W(32)) u_lat1 (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid && !sel), .ld_func3(ld_func3),
      .ld_addr(ld_addr), .ld_stall(st1), .ld_wb_valid(wbv1), .ld_wb_data(wbd1),
      .ld_err(err1), .dm_re(re1), .dm_addr(addr1), .dm_rdata(rd1)
   );

   load_unit #(.MEM_LATENCY(4), .ADDR_W(32)) u_lat4 (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid && sel), .ld_func3(ld_func3),
      .ld_addr(ld_addr), .ld_stall(st4), .ld_wb_valid(wbv4), .ld_wb_data(wbd4),
      .ld_err(err4), .dm_re(re4), .dm_addr(addr4), .dm_rdata(rd4)
   );

   assign o_stall = sel ? st4 : st1;
   assign o_wbv   = sel ? wbv4 : wbv1;
   assign o_data  = sel ? wbd4 : wbd1;
   assign o_err   = sel ? err4 : err1;
   assign o_re    = sel ? re4 : re1;
   assign o_addr  = sel ? addr4 : addr1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: data read on dm_re appears exactly MEM_LATENCY cycles later,
   // with random garbage in every other cycle.
   always @(posedge clk) begin
      p1    <= re1 ? mem[addr1[9:2]] : $urandom;
      p4[0] <= re4 ? mem[addr4[9:2]] : $urandom;
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
   end
   assign rd1 = p1;
   assign rd4 = p4[3];

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off,
                                            input logic [31:0] w);
      longint unsigned wide, v, bits;
      wide = w;
      case (f3)
         3'b000, 3'b100: bits = 8;
         3'b001, 3'b101: bits = 16;
         default: return w;
      endcase
      v = (wide >> (8 * off)) % (64'd1 << bits);
      if (f3[2] == 1'b0 && v >= (64'd1 << (bits - 1)))
         v = v + 64'h1_0000_0000 - (64'd1 << bits);
      return v[31:0];
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; sel = 1'b0; ld_valid = 1'b1; ld_func3 = 3'b010; ld_addr = 32'h100;
      #7;
      checks++;
      if ({o_stall, o_wbv, o_err, o_re} !== 4'b0 || o_data !== 32'h0 || o_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: stall=%b wbv=%b err=%b re=%b data=%h addr=%h required all 0",
                  o_stall, o_wbv, o_err, o_re, o_data, o_addr);
      end
      ld_valid = 1'b0;
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One complete load on the selected instance, checked cycle by cycle.
   task automatic test_load(input bit s, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] w);
      int          lat, off;
      bit          legal, mis, trap;
      logic [31:0] exp_data, exp_addr;
      lat   = s ? 4 : 1;
      off   = int'(a[1:0]);
      legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      mis   = ((f3 == 3'b001 || f3 == 3'b101) && off % 2 == 1) || (f3 == 3'b010 && off != 0);
      trap  = !legal || (TRAP && mis);
      if (!TRAP && mis) off = (f3 == 3'b010) ? 0 : off - 1;
      exp_data = ref_load(f3, off, w);
      exp_addr = trap ? 32'h0 : {a[31:2], 2'b00};
      mem[a[9:2]] = w;
      sel = s; ld_valid = 1'b1; ld_func3 = f3; ld_addr = a;
      @(negedge clk);
      checks++;
      if (o_err !== trap || o_re !== !trap || o_stall !== !trap || o_wbv !== 1'b0) begin
         failures++;
         $display("FAIL t0_ctrl f3=%b a=%h: err=%b re=%b stall=%b wbv=%b required err=%b re=%b stall=%b wbv=0",
                  f3, a, o_err, o_re, o_stall, o_wbv, trap, !trap, !trap);
      end
      checks++;
      if (o_addr !== exp_addr) begin
         failures++;
         $display("FAIL t0_dm_addr a=%h: got %h required %h", a, o_addr, exp_addr);
      end
      if (!trap) begin
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (o_stall !== 1'b1 || o_wbv !== 1'b0 || o_re !== 1'b0 || o_err !== 1'b0) begin
               failures++;
               $display("FAIL wait_cycle%0d lat=%0d: stall=%b wbv=%b re=%b err=%b required 1 0 0 0",
                        k, lat, o_stall, o_wbv, o_re, o_err);
            end
         end
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if (o_wbv !== 1'b1 || o_stall !== 1'b0 || o_re !== 1'b0) begin
            failures++;
            $display("FAIL resp_ctrl lat=%0d: wbv=%b stall=%b re=%b required 1 0 0",
                     lat, o_wbv, o_stall, o_re);
         end
         checks++;
         if (o_data !== exp_data) begin
            failures++;
            $display("FAIL resp_data f3=%b a=%h w=%h: got %h required %h",
                     f3, a, w, o_data, exp_data);
         end
      end
      @(posedge clk); #1;
      ld_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (o_wbv !== 1'b0 || o_data !== 32'h0 || o_stall !== 1'b0 || o_re !== 1'b0) begin
         failures++;
         $display("FAIL after_load: wbv=%b data=%h stall=%b re=%b required all 0",
                  o_wbv, o_data, o_stall, o_re);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      test_load(1'b0, 3'b010, 32'h100, 32'hDEADBEEF);
      test_load(1'b0, 3'b000, 32'h103, 32'h80FF7F01);
      test_load(1'b0, 3'b100, 32'h103, 32'h80FF7F01);
      test_load(1'b0, 3'b001, 32'h102, 32'h8001FFFF);
      test_load(1'b0, 3'b101, 32'h102, 32'h8001FFFF);
      test_load(1'b0, 3'b010, 32'h102, 32'h11223344);
      test_load(1'b0, 3'b011, 32'h104, 32'h55667788);
      test_load(1'b1, 3'b110, 32'h108, 32'h99AABBCC);
      test_load(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      test_load(1'b1, 3'b001, 32'h101, 32'h1234F678);
   endtask

   task automatic test_abort;
      mem[8'h80] = 32'hCAFEF00D;
      sel = 1'b1; ld_valid = 1'b1; ld_func3 = 3'b010; ld_addr = 32'h200;
      for (int t = 0; t <= 5; t++) begin
         if (t == 2) ld_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (o_stall !== (t < 2) || o_wbv !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL abort_T%0d: stall=%b wbv=%b data=%h required stall=%b wbv=0 data=0",
                     t, o_stall, o_wbv, o_data, t < 2);
         end
         @(posedge clk); #1;
      end
      test_load(1'b1, 3'b010, 32'h204, 32'h0BADC0DE);
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         test_load(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      end
   endtask

   task automatic test_async_reset;
      mem[8'hC0] = 32'h76543210;
      sel = 1'b1; ld_valid = 1'b1; ld_func3 = 3'b010; ld_addr = 32'h300;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({o_stall, o_wbv, o_err, o_re} !== 4'b0 || o_data !== 32'h0 || o_addr !== 32'h0) begin
         failures++;
         $display("FAIL async_reset: stall=%b wbv=%b err=%b re=%b data=%h addr=%h required all 0",
                  o_stall, o_wbv, o_err, o_re, o_data, o_addr);
      end
      ld_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (o_wbv !== 1'b0 || o_stall !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet%0d: wbv=%b stall=%b required 0 0", k, o_wbv, o_stall);
         end
         @(posedge clk); #1;
      end
      test_load(1'b0, 3'b010, 32'h100, 32'hDEADBEEF);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      foreach (mem[i]) mem[i] = 32'h0;
      test_reset;
      test_directed;
      test_abort;
      test_random;
      test_async_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
